// File: rtl/arith_op_sequencer.sv
// Command sequencer for the shared add/sub/mul/div units (start / working / ack handshake).
// Optional ISSUE-phase timeout is enabled by defining ARITH_SEQ_TIMEOUT_EN.
module arith_op_sequencer #(
  parameter int WIDTH   = 64,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [1:0]       op_code,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_err,
  output logic [3:0]       unit_start,
  output logic [3:0]       unit_ack,
  output logic [WIDTH-1:0] unit_a,
  output logic [WIDTH-1:0] unit_b,
  input  logic [3:0]       unit_working,
  input  logic [WIDTH-1:0] add_result,
  input  logic [WIDTH-1:0] sub_result,
  input  logic [WIDTH-1:0] mul_result,
  input  logic [WIDTH-1:0] div_result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GRANT = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       sel;
  logic [3:0]       sel_onehot;
  logic             accept;
  logic             working_sel;
  logic             timeout_hit;
  logic [WIDTH-1:0] result_mux;

  assign op_ready    = (state == IDLE);
  assign res_valid   = (state == RESP);
  assign accept      = op_valid && op_ready;
  assign sel_onehot  = 4'b0001 << sel;
  assign working_sel = unit_working[sel];

  always_comb begin
    result_mux = add_result;
    case (sel)
      2'd0:    result_mux = add_result;
      2'd1:    result_mux = sub_result;
      2'd2:    result_mux = mul_result;
      default: result_mux = div_result;
    endcase
  end

`ifdef ARITH_SEQ_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] issue_cnt;

  // Counter holds the number of ISSUE cycles already spent; working wins on the last one.
  assign timeout_hit = (state == ISSUE) && !working_sel && (issue_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt <= '0;
    end else if (accept) begin
      issue_cnt <= '0;
    end else if (state == ISSUE) begin
      issue_cnt <= issue_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_err <= 1'b0;
    end else if (state == GRANT) begin
      res_err <= 1'b0;
    end else if (timeout_hit) begin
      res_err <= 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign res_err        = 1'b0;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE: begin
        if (working_sel)      state_nxt = GRANT;
        else if (timeout_hit) state_nxt = RESP;
      end
      GRANT:   state_nxt = RESP;
      default: if (res_ready) state_nxt = IDLE;
    endcase
  end

  // Start/ack are pure state decodes so an async reset clears them without a clock edge.
  always_comb begin
    unit_start = 4'b0000;
    unit_ack   = 4'b0000;
    case (state)
      ISSUE: unit_start = sel_onehot;
      GRANT: begin
        unit_start = sel_onehot;
        unit_ack   = sel_onehot;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel      <= 2'd0;
      unit_a   <= '0;
      unit_b   <= '0;
      res_data <= '0;
    end else begin
      if (accept) begin
        sel    <= op_code;
        unit_a <= op_a;
        unit_b <= op_b;
      end
      if (state == GRANT) begin
        res_data <= result_mux;
      end else if (timeout_hit) begin
        res_data <= '0;
      end
    end
  end

endmodule

// File: doc/arith_op_sequencer.md
# arith_op_sequencer

Command-side controller for the shared arithmetic units (add, sub, mul, div) that use the start / working / ack handshake. It accepts one operation at a time from a host over a valid/ready port, asserts `start` on the selected unit, and waits for that unit's `working`. It then supplies the acknowledge the unit needs before its result is valid, captures the result, and returns it to the host. It sits between the host command path and the unit bank, and is the only driver of unit `start`/ack lines.

## Interface
- `WIDTH`, 64, operand/result width
- `TIMEOUT`, 15, max cycles waiting for unit `working` (used only with timeout macro)
- `clk` input 1 — single clock, rising edge
- `rst` input 1 — asynchronous, active-high reset
- `op_valid` input 1 — host command valid
- `op_ready` output 1 — sequencer can accept command
- `op_code` input 2 — 0 add, 1 sub, 2 mul, 3 div
- `op_a`, `op_b` input WIDTH — host operands
- `res_valid` output 1 — result available
- `res_ready` input 1 — host consumes result
- `res_data` output WIDTH — captured result
- `res_err` output 1 — command ended by timeout
- `unit_start` output 4 — one-hot start, bit index = op_code
- `unit_ack` output 4 — acknowledge to units, bit index = op_code
- `unit_a`, `unit_b` output WIDTH — registered operands broadcast to all units
- `unit_working` input 4 — per-unit working flags
- `add_result`, `sub_result`, `mul_result`, `div_result` input WIDTH — unit results

## Operation
- States: IDLE, ISSUE, GRANT, RESP.
- IDLE: `op_ready`=1. On `op_valid && op_ready`, register op_code into `sel`, and op_a/op_b into `unit_a`/`unit_b`. Go to ISSUE.
- ISSUE: `unit_start[sel]`=1, all other start bits 0, `unit_ack`=0. When `unit_working[sel]`=1 is sampled, go to GRANT. Working bits of non-selected units are ignored.
- GRANT: `unit_start[sel]`=1 and `unit_ack[sel]`=1, all other bits 0. After exactly one cycle:
  - Capture the result mux output (`sel`: add/sub/mul/div) into `res_data`.
  - Clear `res_err`.
  - Go to RESP.
- RESP: `res_valid`=1, with `res_data`/`res_err` held stable. `unit_start`=0 and `unit_ack`=0. When `res_valid && res_ready`, go to IDLE.
- `op_ready` is 1 only in IDLE. There is no command queueing.
- Results pass through unmodified. Modulo 2^WIDTH wrap is the unit's behaviour (e.g. sub 0−1 = all ones).
- Reset values: state IDLE, `op_ready`=1, `res_valid`=0, `res_data`=0, `res_err`=0, `unit_start`=0, `unit_ack`=0, `unit_a`=0, `unit_b`=0, `sel`=0, timeout counter 0.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronous). The in-flight command is dropped with no response.

## Timing
- All outputs are registered or decoded from state. There are no combinational paths from inputs to outputs, except `op_ready`, which is a state decode.
- Accept edge E0. ISSUE is the cycle after E0. With `unit_working[sel]` already high, GRANT is the next cycle and capture happens at the end of GRANT. `res_valid` rises 3 cycles after E0 (minimum latency).
- Each cycle `unit_working` stays low in ISSUE adds one cycle of latency.
- Back-to-back: after a consume edge, `op_ready`=1 the next cycle. Minimum command period is 4 cycles.

## Configuration
- `ARITH_SEQ_TIMEOUT_EN` defined:
  - A counter clears on entry to ISSUE and increments each ISSUE cycle.
  - If `unit_working[sel]` is not seen after `TIMEOUT` ISSUE cycles, go to RESP with `res_err`=1 and `res_data`=0, without asserting ack.
  - Working seen on the same cycle the count reaches `TIMEOUT` takes precedence, and the command proceeds to GRANT.
- Not defined: there is no counter. ISSUE waits indefinitely, and `res_err` is tied 0.

## Test plan
- Sub with op_a=100, op_b=58 (`sub_result` model = a−b), working asserted immediately → `unit_start`=0010. Then `unit_ack`=0010 for exactly one cycle, and `res_valid` 3 cycles after accept with `res_data`=42, `res_err`=0.
- Add, with working delayed 4 cycles → `res_valid` 7 cycles after accept. `unit_start` holds 0001 throughout ISSUE, and `unit_ack` stays 0 until GRANT.
- Sub with op_a=0, op_b=1 followed by a back-to-back mul 7×6 → `res_data`=0xFFFF_FFFF_FFFF_FFFF, then 42. Second accept occurs one cycle after the first consume.
- `res_ready` held low 5 cycles in RESP → `res_valid`, `res_data` and `op_ready`=0 remain stable. `op_valid` pulses during that time are not accepted.
- With `ARITH_SEQ_TIMEOUT_EN` and TIMEOUT=15: div with working never asserted → RESP after 15 ISSUE cycles with `res_err`=1, `res_data`=0, and `unit_ack` never set. Without the macro the block stays in ISSUE for 100+ cycles.
- `rst` pulsed mid-ISSUE, between clock edges → `unit_start` goes to 0 without waiting for a clock edge. After release, `op_ready`=1 and no `res_valid` is produced for the dropped command.
